// File: rtl/ofs_plat_avalon_mem_rdwr_merge.sv
// ----------------------------------------------------------------------------
// ofs_plat_avalon_mem_rdwr_merge
//
// Merges a split read/write Avalon memory bus (independent rd_* and wr_*
// request channels) onto one shared-address Avalon memory sink (m_*).
// Reads and writes are arbitrated round-robin at burst boundaries, and write
// bursts are kept atomic. Responses are routed back to their own channels in
// the same cycle.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   rd_*                  read request channel (one command beat per burst)
//   rd_readdata/...       read response returned to the read channel
//   wr_*                  write request channel (one beat per data word)
//   wr_writeresponse*     write response returned to the write channel
//   m_*                   merged Avalon sink port (no waitrequest allowance)
//
// Request path is combinational from the registered grant state and adds
// no latency. A command stalled by m_waitrequest keeps its grant until it is
// accepted, so the merged command stays stable as Avalon requires.
// ----------------------------------------------------------------------------
module ofs_plat_avalon_mem_rdwr_merge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int RESPONSE_WIDTH  = 2,
  parameter int USER_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,

  // Read request / response channel
  input  logic [ADDR_WIDTH-1:0]      rd_address,
  input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
  input  logic [DATA_WIDTH/8-1:0]    rd_byteenable,
  input  logic [USER_WIDTH-1:0]      rd_user,
  input  logic                       rd_read,
  output logic                       rd_waitrequest,
  output logic [DATA_WIDTH-1:0]      rd_readdata,
  output logic                       rd_readdatavalid,
  output logic [RESPONSE_WIDTH-1:0]  rd_response,
  output logic [USER_WIDTH-1:0]      rd_readresponseuser,

  // Write request / response channel
  input  logic [ADDR_WIDTH-1:0]      wr_address,
  input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
  input  logic [DATA_WIDTH-1:0]      wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]    wr_byteenable,
  input  logic [USER_WIDTH-1:0]      wr_user,
  input  logic                       wr_write,
  output logic                       wr_waitrequest,
  output logic                       wr_writeresponsevalid,
  output logic [RESPONSE_WIDTH-1:0]  wr_response,
  output logic [USER_WIDTH-1:0]      wr_writeresponseuser,

  // Merged sink port
  output logic [ADDR_WIDTH-1:0]      m_address,
  output logic [BURST_CNT_WIDTH-1:0] m_burstcount,
  output logic [DATA_WIDTH-1:0]      m_writedata,
  output logic [DATA_WIDTH/8-1:0]    m_byteenable,
  output logic [USER_WIDTH-1:0]      m_user,
  output logic                       m_read,
  output logic                       m_write,
  input  logic                       m_waitrequest,
  input  logic [DATA_WIDTH-1:0]      m_readdata,
  input  logic                       m_readdatavalid,
  input  logic [RESPONSE_WIDTH-1:0]  m_response,
  input  logic [USER_WIDTH-1:0]      m_readresponseuser,
  input  logic                       m_writeresponsevalid,
  input  logic [USER_WIDTH-1:0]      m_writeresponseuser
);

  localparam logic [BURST_CNT_WIDTH-1:0] BCNT_ONE = BURST_CNT_WIDTH'(1);

  typedef enum logic {ST_ARB, ST_WR_BURST} state_t;
  typedef enum logic {CH_RD, CH_WR} chan_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_WR} grant_t;

  state_t                     state;
  chan_t                      rr_last;   // channel that won the last burst
  logic                       hold;      // a stalled command owns the bus
  chan_t                      held_chan;
  logic [BURST_CNT_WIDTH-1:0] wr_rem;    // write beats left in the burst
  grant_t                     grant;

  logic cmd_valid;
  logic cmd_stall;

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves grant unassigned,
    // which would otherwise infer a latch.
    grant = GNT_NONE;
    if (state == ST_WR_BURST) begin
      grant = GNT_WR;
    end else if (hold) begin
      grant = (held_chan == CH_WR) ? GNT_WR : GNT_RD;
    end else if (rd_read && (!wr_write || (rr_last == CH_WR))) begin
      grant = GNT_RD;
    end else if (wr_write) begin
      grant = GNT_WR;
    end
  end

  // --------------------------------------------------------------------------
  // Merged request path; reset forces the channels quiet and stalled.
  // --------------------------------------------------------------------------
  assign m_read         = !reset && (grant == GNT_RD) && rd_read;
  assign m_write        = !reset && (grant == GNT_WR) && wr_write;
  assign rd_waitrequest = reset || (grant != GNT_RD) || m_waitrequest;
  assign wr_waitrequest = reset || (grant != GNT_WR) || m_waitrequest;

  assign m_address    = (grant == GNT_WR) ? wr_address    : rd_address;
  assign m_burstcount = (grant == GNT_WR) ? wr_burstcount : rd_burstcount;
  assign m_byteenable = (grant == GNT_WR) ? wr_byteenable : rd_byteenable;
  assign m_user       = (grant == GNT_WR) ? wr_user       : rd_user;
  assign m_writedata  = wr_writedata;

  assign cmd_valid = m_read || m_write;
  assign cmd_stall = cmd_valid && m_waitrequest;

  // --------------------------------------------------------------------------
  // Response pass-through
  // --------------------------------------------------------------------------
  assign rd_readdata           = m_readdata;
  assign rd_readdatavalid      = m_readdatavalid;
  assign rd_response           = m_response;
  assign rd_readresponseuser   = m_readresponseuser;
  assign wr_writeresponsevalid = m_writeresponsevalid;
  assign wr_response           = m_response;
  assign wr_writeresponseuser  = m_writeresponseuser;

  // --------------------------------------------------------------------------
  // Arbitration state
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ARB;
      rr_last   <= CH_WR;     // read wins the first contention
      hold      <= 1'b0;
      held_chan <= CH_RD;
      wr_rem    <= '0;
    end else begin
      // Keep the grant of a stalled command; release it on acceptance.
      hold <= cmd_stall;
      if (cmd_stall) begin
        held_chan <= m_write ? CH_WR : CH_RD;
      end

      if (m_read && !m_waitrequest) begin
        rr_last <= CH_RD;
      end

      if (m_write && !m_waitrequest) begin
        if (state == ST_ARB) begin
          rr_last <= CH_WR;
          // burstcount 0 falls through here and is treated as one beat
          if (wr_burstcount > BCNT_ONE) begin
            wr_rem <= wr_burstcount - BCNT_ONE;
            state  <= ST_WR_BURST;
          end
        end else begin
          wr_rem <= wr_rem - BCNT_ONE;
          if (wr_rem == BCNT_ONE) begin
            state <= ST_ARB;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Simulation-only protocol checks
  // --------------------------------------------------------------------------
  always @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(rd_read) && !$isunknown(wr_write))
        else $fatal(1, "rd_read or wr_write is unknown outside reset");
      assert (!(m_read && m_write))
        else $fatal(1, "m_read and m_write asserted together");
      if (m_write && !m_waitrequest && (state == ST_ARB)) begin
        assert (wr_burstcount != '0)
          else $error("write burst with burstcount 0, treated as 1");
      end
    end
  end

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_merge.sv
// ----------------------------------------------------------------------------
// tb_ofs_plat_avalon_mem_rdwr_merge
//
// Self-checking bench for the read/write merge stage. A cycle-level reference
// arbiter predicts the merged command every cycle; its prediction is pushed to
// a scoreboard queue when the inputs are driven and popped and compared when
// the DUT outputs are sampled on the falling edge. Directed sequences add
// explicit checks on ordering, hold stability, burst length, reset and
// response routing.
// ----------------------------------------------------------------------------
module tb_ofs_plat_avalon_mem_rdwr_merge;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 7;
  localparam int RW = 2;
  localparam int UW = 8;
  localparam int BE = DW / 8;

  logic          clk;
  logic          reset;
  logic [AW-1:0] rd_address;
  logic [BW-1:0] rd_burstcount;
  logic [BE-1:0] rd_byteenable;
  logic [UW-1:0] rd_user;
  logic          rd_read;
  logic          rd_waitrequest;
  logic [DW-1:0] rd_readdata;
  logic          rd_readdatavalid;
  logic [RW-1:0] rd_response;
  logic [UW-1:0] rd_readresponseuser;
  logic [AW-1:0] wr_address;
  logic [BW-1:0] wr_burstcount;
  logic [DW-1:0] wr_writedata;
  logic [BE-1:0] wr_byteenable;
  logic [UW-1:0] wr_user;
  logic          wr_write;
  logic          wr_waitrequest;
  logic          wr_writeresponsevalid;
  logic [RW-1:0] wr_response;
  logic [UW-1:0] wr_writeresponseuser;
  logic [AW-1:0] m_address;
  logic [BW-1:0] m_burstcount;
  logic [DW-1:0] m_writedata;
  logic [BE-1:0] m_byteenable;
  logic [UW-1:0] m_user;
  logic          m_read;
  logic          m_write;
  logic          m_waitrequest;
  logic [DW-1:0] m_readdata;
  logic          m_readdatavalid;
  logic [RW-1:0] m_response;
  logic [UW-1:0] m_readresponseuser;
  logic          m_writeresponsevalid;
  logic [UW-1:0] m_writeresponseuser;

  ofs_plat_avalon_mem_rdwr_merge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
    .RESPONSE_WIDTH(RW), .USER_WIDTH(UW)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_address(rd_address), .rd_burstcount(rd_burstcount),
    .rd_byteenable(rd_byteenable), .rd_user(rd_user), .rd_read(rd_read),
    .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata),
    .rd_readdatavalid(rd_readdatavalid), .rd_response(rd_response),
    .rd_readresponseuser(rd_readresponseuser),
    .wr_address(wr_address), .wr_burstcount(wr_burstcount),
    .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable),
    .wr_user(wr_user), .wr_write(wr_write), .wr_waitrequest(wr_waitrequest),
    .wr_writeresponsevalid(wr_writeresponsevalid), .wr_response(wr_response),
    .wr_writeresponseuser(wr_writeresponseuser),
    .m_address(m_address), .m_burstcount(m_burstcount),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_user(m_user),
    .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_response(m_response), .m_readresponseuser(m_readresponseuser),
    .m_writeresponsevalid(m_writeresponsevalid),
    .m_writeresponseuser(m_writeresponseuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observable merged-port state for one cycle. Request fields are zeroed
  // when no command is presented so idle-cycle don't-cares never compare.
  typedef struct packed {
    logic          mr;
    logic          mw;
    logic          rwait;
    logic          wwait;
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic [BE-1:0] be;
    logic [UW-1:0] user;
    logic [DW-1:0] wdata;
  } beat_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arbiter state
  bit mdl_burst;
  int mdl_rem;
  bit mdl_rr_wr;     // last winner was the write channel
  bit mdl_hold;
  bit mdl_hold_wr;
  bit last_rd_acc;   // model-predicted acceptances of the last cycle
  bit last_wr_acc;
  int mdl_rd_acc = 0;
  int mdl_wr_acc = 0;
  int dut_rd_acc = 0;
  int dut_wr_acc = 0;

  beat_t exp_q[$];
  beat_t last_d;
  logic [31:0] acc_bits;   // 1 = write beat, 0 = read, newest in bit 0
  int          acc_n;

  task automatic mdl_reset();
    mdl_burst   = 1'b0;
    mdl_rem     = 0;
    mdl_rr_wr   = 1'b1;
    mdl_hold    = 1'b0;
    mdl_hold_wr = 1'b0;
  endtask

  // One bus cycle: predict, sample on the falling edge, compare, advance.
  task automatic tick();
    beat_t e;
    beat_t d;
    beat_t p;
    bit    g_rd;
    bit    g_wr;
    bit    acc;
    g_rd = 1'b0;
    g_wr = 1'b0;
    if (mdl_burst) g_wr = 1'b1;
    else if (mdl_hold) begin
      g_wr = mdl_hold_wr;
      g_rd = !mdl_hold_wr;
    end else if (rd_read && (!wr_write || mdl_rr_wr)) g_rd = 1'b1;
    else if (wr_write) g_wr = 1'b1;

    e       = '0;
    e.mr    = g_rd && rd_read;
    e.mw    = g_wr && wr_write;
    e.rwait = !g_rd || m_waitrequest;
    e.wwait = !g_wr || m_waitrequest;
    if (e.mr) begin
      e.addr = rd_address; e.bc = rd_burstcount;
      e.be   = rd_byteenable; e.user = rd_user;
    end else if (e.mw) begin
      e.addr = wr_address; e.bc = wr_burstcount;
      e.be   = wr_byteenable; e.user = wr_user;
    end
    e.wdata = wr_writedata;
    exp_q.push_back(e);

    @(negedge clk);
    d       = '0;
    d.mr    = m_read;
    d.mw    = m_write;
    d.rwait = rd_waitrequest;
    d.wwait = wr_waitrequest;
    if (m_read || m_write) begin
      d.addr = m_address; d.bc = m_burstcount;
      d.be   = m_byteenable; d.user = m_user;
    end
    d.wdata = m_writedata;
    last_d  = d;
    p = exp_q.pop_front();
    check("cycle", d, p);
    if (m_read && !m_waitrequest) begin
      dut_rd_acc++;
      acc_bits = {acc_bits[30:0], 1'b0};
      acc_n++;
    end
    if (m_write && !m_waitrequest) begin
      dut_wr_acc++;
      acc_bits = {acc_bits[30:0], 1'b1};
      acc_n++;
    end

    @(posedge clk);
    acc         = (p.mr || p.mw) && !m_waitrequest;
    last_rd_acc = acc && p.mr;
    last_wr_acc = acc && p.mw;
    mdl_hold    = (p.mr || p.mw) && m_waitrequest;
    mdl_hold_wr = p.mw;
    if (last_rd_acc) begin
      mdl_rr_wr = 1'b0;
      mdl_rd_acc++;
    end
    if (last_wr_acc) begin
      mdl_wr_acc++;
      if (!mdl_burst) begin
        mdl_rr_wr = 1'b1;
        if (int'(wr_burstcount) > 1) begin
          mdl_burst = 1'b1;
          mdl_rem   = int'(wr_burstcount) - 1;
        end
      end else begin
        mdl_rem--;
        if (mdl_rem == 0) mdl_burst = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rd_read = 1'b0; wr_write = 1'b0; m_waitrequest = 1'b0;
  endtask

  initial begin
    int  nw;
    bit  rd_done;
    int  wr_left;
    int  wr_bc;
    logic [AW-1:0] rd_next;
    logic [AW-1:0] wr_base;

    reset = 1'b1;
    rd_address = '0; rd_burstcount = 7'd1; rd_byteenable = '1; rd_user = '0;
    wr_address = '0; wr_burstcount = 7'd1; wr_writedata = '0;
    wr_byteenable = '1; wr_user = '0;
    idle_inputs();
    m_readdata = '0; m_readdatavalid = 1'b0; m_response = '0;
    m_readresponseuser = '0; m_writeresponsevalid = 1'b0;
    m_writeresponseuser = '0;
    acc_bits = '0; acc_n = 0;
    last_rd_acc = 1'b0; last_wr_acc = 1'b0;
    last_d = '0;
    mdl_reset();

    // ---- reset state: requests present but nothing may pass --------------
    repeat (2) @(posedge clk);
    #1;
    rd_read = 1'b1; wr_write = 1'b1;
    #1;
    check("rst_m_read", m_read, 1'b0);
    check("rst_m_write", m_write, 1'b0);
    check("rst_rd_wait", rd_waitrequest, 1'b1);
    check("rst_wr_wait", wr_waitrequest, 1'b1);
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ---- response routing, read and write response in the same cycle -----
    m_readdatavalid = 1'b1; m_readdata = 32'hA5; m_readresponseuser = 8'h3C;
    m_writeresponsevalid = 1'b1; m_writeresponseuser = 8'h5A;
    m_response = 2'd2;
    #1;
    check("rsp_rvalid", rd_readdatavalid, 1'b1);
    check("rsp_rdata", rd_readdata, 32'hA5);
    check("rsp_ruser", rd_readresponseuser, 8'h3C);
    check("rsp_rresp", rd_response, 2'd2);
    check("rsp_wvalid", wr_writeresponsevalid, 1'b1);
    check("rsp_wuser", wr_writeresponseuser, 8'h5A);
    check("rsp_wresp", wr_response, 2'd2);
    m_readdatavalid = 1'b0; m_writeresponsevalid = 1'b0;
    #1;
    check("rsp_rvalid_off", rd_readdatavalid, 1'b0);
    check("rsp_wvalid_off", wr_writeresponsevalid, 1'b0);

    // ---- contention: read vs 4-beat writes, expect R WWWW R WWWW ----------
    rd_read = 1'b1; rd_address = 16'h1000;
    wr_write = 1'b1; wr_burstcount = 7'd4; wr_address = 16'h2000;
    wr_writedata = 32'h100;
    acc_bits = '0; acc_n = 0;
    for (int i = 0; i < 40 && acc_n < 10; i++) begin
      tick();
      if (last_rd_acc) rd_address = rd_address + 1'b1;
      if (last_wr_acc) wr_writedata = wr_writedata + 1'b1;
    end
    check("contention_beats", acc_n, 10);
    check("contention_order", acc_bits[9:0], 10'b01111_01111);
    idle_inputs();
    tick();

    // ---- hold: stalled read keeps the bus while a write arrives -----------
    rd_read = 1'b1; rd_address = 16'h0050;
    tick();                                  // read wins, rr_last = RD
    rd_address = 16'h0123; m_waitrequest = 1'b1;
    tick();
    check("hold_c1_read", last_d.mr, 1'b1);
    check("hold_c1_addr", last_d.addr, 16'h0123);
    wr_write = 1'b1; wr_burstcount = 7'd1; wr_address = 16'h0777;
    for (int i = 2; i <= 4; i++) begin
      if (i == 4) m_waitrequest = 1'b0;
      tick();
      check("hold_read", last_d.mr, 1'b1);
      check("hold_addr", last_d.addr, 16'h0123);
      check("hold_no_write", last_d.mw, 1'b0);
      check("hold_wr_wait", last_d.wwait, 1'b1);
    end
    rd_read = 1'b0;
    tick();
    check("hold_then_write", last_d.mw, 1'b1);
    idle_inputs();
    tick();

    // ---- burst boundary: burstcount 1 returns to arbitration at once ------
    wr_write = 1'b1; wr_burstcount = 7'd1; wr_address = 16'h0300;
    tick();
    wr_write = 1'b0; rd_read = 1'b1; rd_address = 16'h0301;
    tick();
    check("bc1_read_next", last_d.mr && !last_d.rwait, 1'b1);
    rd_read = 1'b0;
    tick();

    // ---- burst boundary: 127 beats, read waiting, random stalls -----------
    rd_read = 1'b1; rd_address = 16'h0077;
    wr_write = 1'b1; wr_burstcount = 7'h7F; wr_address = 16'h0400;
    nw = 0; rd_done = 1'b0;
    for (int i = 0; i < 3000 && !rd_done; i++) begin
      m_waitrequest = ($urandom_range(0, 2) == 0);
      tick();
      if (last_d.mw && !last_d.wwait) begin
        nw++;
        wr_writedata = $urandom;
      end
      if (last_d.mr && !last_d.rwait) rd_done = 1'b1;
    end
    check("bc127_read_done", rd_done, 1'b1);
    check("bc127_beats", nw, 127);
    idle_inputs();
    tick();

    // ---- reset in the middle of a write burst ----------------------------
    wr_write = 1'b1; wr_burstcount = 7'd5; wr_address = 16'h0500;
    tick();
    tick();                                  // two beats done, three left
    reset = 1'b1;
    #1;
    check("midrst_m_write", m_write, 1'b0);
    check("midrst_wr_wait", wr_waitrequest, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_reset();
    rd_read = 1'b1; rd_address = 16'h0600; wr_burstcount = 7'd2;
    tick();
    check("midrst_read_first", last_d.mr, 1'b1);
    idle_inputs();
    tick();
    tick();

    // ---- random traffic against the reference arbiter --------------------
    rd_next = 16'h8000; wr_base = 16'hC000; wr_left = 0; wr_bc = 1;
    last_rd_acc = 1'b0; last_wr_acc = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!rd_read || last_rd_acc) begin
        rd_read = ($urandom_range(0, 2) != 0);
        if (rd_read) begin
          rd_address    = rd_next;
          rd_next       = rd_next + 1'b1;
          rd_burstcount = 7'($urandom_range(1, 8));
          rd_byteenable = 4'($urandom);
          rd_user       = 8'($urandom);
        end
      end
      if (last_wr_acc) wr_left--;
      if (!wr_write || last_wr_acc) begin
        if (wr_left == 0) begin
          wr_bc   = $urandom_range(1, 4);
          wr_left = wr_bc;
          wr_base = wr_base + 16'h10;
        end
        wr_write      = ($urandom_range(0, 3) != 0);
        wr_address    = wr_base;
        wr_burstcount = 7'(wr_bc);
        wr_writedata  = $urandom;
        wr_byteenable = 4'($urandom);
        wr_user       = 8'($urandom);
      end
      m_waitrequest = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_inputs();
    tick();

    check("read_beats_total", dut_rd_acc, mdl_rd_acc);
    check("write_beats_total", dut_wr_acc, mdl_wr_acc);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
